// File: rtl/mem_arbiter.sv
// Arbitrates the single off-chip memory port between ICACHE and DCACHE block transactions.
// DCACHE has fixed priority; a streak counter forces an ICACHE grant after STARVE_LIMIT D grants.
module mem_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, TURN} state_t;

    state_t            state_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        grant_q;
    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;

    logic req_i;
    logic req_d;
    logic pick_d;

    assign req_i  = i_read | i_write;
    assign req_d  = d_read | d_write;
    assign pick_d = req_d && !(req_i && (starve_q == LIMIT));

    // Streak value taken on a DCACHE grant: counts only while fetch is actually waiting.
    assign starve_d = !req_i            ? '0 :
                      (starve_q == LIMIT) ? LIMIT :
                      starve_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            grant_q     <= 2'b00;
            starve_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q     <= BUSY_D;
                        grant_q     <= 2'b10;
                        mem_write_q <= d_write;
                        mem_read_q  <= d_read & ~d_write;
                        addr_q      <= d_addr;
                        wdata_q     <= d_wdata;
                        starve_q    <= starve_d;
                    end else if (req_i) begin
                        state_q     <= BUSY_I;
                        grant_q     <= 2'b01;
                        mem_write_q <= i_write;
                        mem_read_q  <= i_read & ~i_write;
                        addr_q      <= i_addr;
                        wdata_q     <= i_wdata;
                        starve_q    <= '0;
                    end else begin
                        starve_q    <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ready) begin
                        state_q     <= TURN;
                        grant_q     <= 2'b00;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                    end
                end
                TURN: begin
                    // Dead cycle so the finished cache can drop its request before re-arbitration.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign grant     = grant_q;

    assign i_ready = (state_q == BUSY_I) & mem_ready;
    assign d_ready = (state_q == BUSY_D) & mem_ready;
    assign i_rdata = {DATA_W{i_ready}} & mem_rdata;
    assign d_rdata = {DATA_W{d_ready}} & mem_rdata;

endmodule
